// File: rtl/fetch_buf.sv
// Prefetching instruction-fetch unit for the bf8b core: pipelined reads into a
// PC-tagged FIFO that feeds decode over a valid/ready handshake.
module fetch_buf #(
    parameter int          DW       = 8,
    parameter int          AW       = 8,
    parameter int          DEPTH    = 4,
    parameter int          LAT      = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [AW-1:0]             flush_pc,
    output logic                      mem_rd,
    output logic [AW-1:0]             mem_addr,
    input  logic [DW-1:0]             mem_data,
    output logic [DW-1:0]             inst_out,
    output logic [AW-1:0]             inst_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(DEPTH + LAT + 2) + 1;
    localparam logic [AW-1:0] START_PC = AW'(RESET_PC);

    logic [AW-1:0] fetch_pc;
    logic [LAT-1:0] pipe_vld;
    logic [AW-1:0] pipe_pc [LAT];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [AW-1:0] fifo_pc [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic push;
    logic pop;
    logic [CW-1:0] committed;
    logic can_issue;

    assign inst_valid = (level != '0);
    assign inst_out   = fifo_data[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];
    assign push       = pipe_vld[LAT-1];
    assign pop        = inst_valid && inst_ready;

    // Slots promised after this edge: buffered + outstanding reads, crediting
    // the pop so a draining FIFO still sustains one read per cycle.
    always_comb begin
        committed = CW'(level) + CW'(mem_rd);
        for (int i = 0; i < LAT; i++) begin
            committed = committed + CW'(pipe_vld[i]);
        end
        if (pop) begin
            committed = committed - CW'(1);
        end
        can_issue = (committed < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= START_PC;
            mem_rd   <= 1'b0;
            mem_addr <= START_PC;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            mem_rd   <= 1'b0;
        end else if (can_issue) begin
            mem_rd   <= 1'b1;
            mem_addr <= fetch_pc;
            fetch_pc <= fetch_pc + AW'(1);
        end else begin
            mem_rd   <= 1'b0;
        end
    end

    // Request pipe: the last stage lines up with mem_data for that request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_pc[i]  <= '0;
            end
        end else begin
            pipe_vld[0] <= mem_rd && !flush;
            pipe_pc[0]  <= mem_addr;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] && !flush;
                pipe_pc[i]  <= pipe_pc[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_data;
                fifo_pc[wr_ptr]   <= pipe_pc[LAT-1];
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_buf.sv
// Bench for fetch_buf: vector tables, directed corner sequences and a random
// phase checked against a queue-based model of outstanding reads.
module tb_fetch_buf;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 4;
    localparam int LAT = 2;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [AW-1:0] flush_pc = '0;
    logic mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] inst_out;
    logic [AW-1:0] inst_pc;
    logic inst_valid;
    logic inst_ready = 1'b0;
    logic [$clog2(DEPTH):0] level;

    int n_cmp = 0;
    int n_err = 0;

    int lvl;
    int ages[$];
    logic [7:0] exp_pc;
    logic [7:0] next_issue;
    logic [7:0] exp_addr;
    bit exp_rd;
    logic [7:0] pop_log[$];

    logic [7:0] mem_q [LAT] = '{default: 8'h00};

    typedef struct {
        bit         ready;
        bit         exp_valid;
        logic [7:0] exp_pc;
        logic [7:0] exp_out;
        int         exp_level;
        bit         exp_rd;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    fetch_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LAT(LAT), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .level(level)
    );

    always #5 clk = ~clk;

    // Memory returns addr^A5 exactly LAT cycles after the request.
    always @(posedge clk) begin
        mem_q[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) mem_q[i] <= mem_q[i-1];
    end
    assign mem_data = mem_q[LAT-1] ^ 8'hA5;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        lvl = 0;
        ages.delete();
        exp_pc = RESET_PC;
        next_issue = RESET_PC;
        exp_addr = RESET_PC;
        exp_rd = 1'b0;
        pop_log.delete();
    endtask

    // Effect of one clock edge: reads land LAT edges after they are sampled,
    // and a new read goes out only if its data is guaranteed a slot.
    task automatic model_edge(input bit rdy, input bit fl, input logic [7:0] fpc);
        if (fl) begin
            lvl = 0;
            ages.delete();
            exp_pc = fpc;
            next_issue = fpc;
            exp_rd = 1'b0;
        end else begin
            if (rdy && lvl > 0) begin
                pop_log.push_back(exp_pc);
                exp_pc = exp_pc + 8'd1;
                lvl--;
            end
            foreach (ages[i]) ages[i] = ages[i] - 1;
            while (ages.size() > 0 && ages[0] == 0) begin
                void'(ages.pop_front());
                lvl++;
            end
            if (exp_rd) ages.push_back(LAT);
            exp_rd = (lvl + ages.size()) < DEPTH;
            if (exp_rd) begin
                exp_addr = next_issue;
                next_issue = next_issue + 8'd1;
            end
        end
    endtask

    task automatic apply_stimulus(input bit rdy, input bit fl, input logic [7:0] fpc);
        inst_ready = rdy;
        flush = fl;
        flush_pc = fpc;
        model_edge(rdy, fl, fpc);
        @(posedge clk);
        @(negedge clk);
        check_output("level", 32'(level), 32'(lvl));
        check_output("inst_valid", 32'(inst_valid), 32'(lvl != 0));
        check_output("mem_rd", 32'(mem_rd), 32'(exp_rd));
        if (exp_rd) check_output("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (lvl > 0) begin
            check_output("inst_pc", 32'(inst_pc), 32'(exp_pc));
            check_output("inst_out", 32'(inst_out), 32'(exp_pc ^ 8'hA5));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        flush_pc = '0;
        inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_level", 32'(level), 0);
        check_output("rst_valid", 32'(inst_valid), 0);
        check_output("rst_mem_rd", 32'(mem_rd), 0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
        check_output("rst_inst_out", 32'(inst_out), 0);
        check_output("rst_inst_pc", 32'(inst_pc), 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].ready, 1'b0, 8'h00);
            check_output($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            check_output($sformatf("vec%0d_mem_rd", i), 32'(mem_rd), 32'(vecs[i].exp_rd));
            check_output($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d_pc", i), 32'(inst_pc), 32'(vecs[i].exp_pc));
                check_output($sformatf("vec%0d_out", i), 32'(inst_out), 32'(vecs[i].exp_out));
            end
        end
    endtask

    initial begin
        int cnt;
        logic [7:0] seq[4];

        // Startup with ready high: three empty cycles, then one instruction per cycle.
        vecs.delete();
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h01});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h02});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 8'hA5, 1, 1'b1, 8'h03});
        vecs.push_back('{1'b1, 1'b1, 8'h01, 8'hA4, 1, 1'b1, 8'h04});
        vecs.push_back('{1'b1, 1'b1, 8'h02, 8'hA7, 1, 1'b1, 8'h05});
        do_reset();
        run_table();

        // Backpressure from reset: four reads total, then level saturates.
        vecs.delete();
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h01});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1, 8'h02});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hA5, 1, 1'b1, 8'h03});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hA5, 2, 1'b0, 8'h03});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hA5, 3, 1'b0, 8'h03});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hA5, 4, 1'b0, 8'h03});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'hA5, 4, 1'b0, 8'h03});
        do_reset();
        run_table();
        for (int i = 0; i < 24; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("drain_count", 32'(pop_log.size() >= 16), 1);
        for (int i = 0; i < 16 && i < pop_log.size(); i++)
            check_output($sformatf("drain_pc%0d", i), 32'(pop_log[i]), 32'(i));

        // Flush with reads in flight.
        do_reset();
        cnt = 0;
        while (!(exp_rd && exp_addr == 8'h05) && cnt < 20) begin
            apply_stimulus(1'b1, 1'b0, 8'h00);
            cnt++;
        end
        check_output("reach_pc05_timeout", 32'(cnt < 20), 1);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'h40);
        check_output("flush_valid_low", 32'(inst_valid), 0);
        pop_log.delete();
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("flush_first_rd", 32'(mem_rd), 1);
        check_output("flush_first_addr", 32'(mem_addr), 32'h40);
        cnt = 0;
        while (!inst_valid && cnt < 10) begin
            apply_stimulus(1'b1, 1'b0, 8'h00);
            cnt++;
        end
        check_output("flush_to_valid", 32'(cnt), 32'(LAT + 1));
        check_output("flush_first_pc", 32'(inst_pc), 32'h40);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("flush_next_pop", 32'(pop_log.size() > 0 ? pop_log[0] : 8'hXX), 32'h40);

        // PC wrap across 2^AW.
        apply_stimulus(1'b1, 1'b1, 8'hFE);
        pop_log.delete();
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
        seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        check_output("wrap_count", 32'(pop_log.size() >= 4), 1);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check_output($sformatf("wrap_pc%0d", i), 32'(pop_log[i]), 32'(seq[i]));

        // Flush on an edge that would also push and pop.
        check_output("simul_pre_level", 32'(level), 1);
        apply_stimulus(1'b1, 1'b1, 8'h80);
        check_output("simul_level", 32'(level), 0);
        check_output("simul_valid", 32'(inst_valid), 0);
        pop_log.delete();
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("simul_next_pop", 32'(pop_log.size() > 0 ? pop_log[0] : 8'hXX), 32'h80);

        // Asynchronous reset mid-stream with three entries buffered.
        cnt = 0;
        while (lvl != 3 && cnt < 10) begin
            apply_stimulus(1'b0, 1'b0, 8'h00);
            cnt++;
        end
        check_output("reach_level3_timeout", 32'(cnt < 10), 1);
        check_output("pre_reset_level", 32'(level), 3);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_level", 32'(level), 0);
        check_output("async_valid", 32'(inst_valid), 0);
        check_output("async_mem_rd", 32'(mem_rd), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("restart_pc", 32'(pop_log.size() > 0 ? pop_log[0] : 8'hXX), 32'(RESET_PC));

        // Random ready and occasional flushes against the model.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
